// File: rtl/core_output_arbiter.sv
// Round-robin merge of four core packet streams onto one 64-bit data / 8-bit ctrl output stream.
// Optional idle-grant timeout with forced release is enabled by defining ARB_GRANT_TIMEOUT_EN.
module core_output_arbiter #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in_data0,
    input  logic [7:0]  in_ctrl0,
    input  logic        in_wr0,
    input  logic        in_req0,
    output logic        in_ack0,
    output logic        in_rdy0,
    input  logic [63:0] in_data1,
    input  logic [7:0]  in_ctrl1,
    input  logic        in_wr1,
    input  logic        in_req1,
    output logic        in_ack1,
    output logic        in_rdy1,
    input  logic [63:0] in_data2,
    input  logic [7:0]  in_ctrl2,
    input  logic        in_wr2,
    input  logic        in_req2,
    output logic        in_ack2,
    output logic        in_rdy2,
    input  logic [63:0] in_data3,
    input  logic [7:0]  in_ctrl3,
    input  logic        in_wr3,
    input  logic        in_req3,
    output logic        in_ack3,
    output logic        in_rdy3,
    output logic [63:0] out_data,
    output logic [7:0]  out_ctrl,
    output logic        out_wr,
    input  logic        out_rdy,
    output logic        grant_timeout
);
    typedef enum logic [1:0] {ArbIdle, ArbXfer, ArbRelease} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick, idx;
    logic                 found, accept, timeout_hit;
    logic [NUM_CORES-1:0] ack_q, ack_d, req, wr, rdy, eligible;
    logic [63:0]          data [NUM_CORES];
    logic [7:0]           ctrl [NUM_CORES];
    logic [63:0]          out_data_q;
    logic [7:0]           out_ctrl_q;
    logic                 out_wr_q, grant_timeout_q;

    assign data = '{in_data0, in_data1, in_data2, in_data3};
    assign ctrl = '{in_ctrl0, in_ctrl1, in_ctrl2, in_ctrl3};
    assign req  = {in_req3, in_req2, in_req1, in_req0};
    assign wr   = {in_wr3, in_wr2, in_wr1, in_wr0};

    // A write after the core has dropped req is not part of the packet.
    assign accept = (state_q == ArbXfer) && wr[sel_q] && out_rdy && req[sel_q];

`ifdef ARB_GRANT_TIMEOUT_EN
    logic [10:0]          idle_cnt_q, idle_cnt_d;
    logic [NUM_CORES-1:0] pend_q, pend_d;

    assign timeout_hit = (state_q == ArbXfer) && req[sel_q] && !accept &&
                         (idle_cnt_q == 11'(TIMEOUT_CYCLES - 1));
    assign eligible    = req & ~pend_q;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        pend_d     = pend_q & req;
        if (state_q == ArbIdle && found) begin
            idle_cnt_d = '0;
        end else if (state_q == ArbXfer) begin
            idle_cnt_d = accept ? 11'd0 : idle_cnt_q + 11'd1;
        end
        // Forced-off core stays out until it lowers req for the stale packet.
        if (timeout_hit) pend_d[sel_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            pend_q     <= pend_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign eligible    = req;
`endif

    // First eligible requester after rr_ptr; rr_ptr itself is scanned last.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ArbIdle;
            sel_q    <= 2'd0;
            rr_ptr_q <= 2'd3;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = ack_q;
        unique case (state_q)
            ArbIdle: begin
                if (found) begin
                    sel_d       = pick;
                    ack_d       = '0;
                    ack_d[pick] = 1'b1;
                    state_d     = ArbXfer;
                end
            end
            ArbXfer: begin
                if (!req[sel_q] || timeout_hit) begin
                    ack_d    = '0;
                    rr_ptr_d = sel_q;
                    state_d  = ArbRelease;
                end
            end
            ArbRelease: state_d = ArbIdle;
            default:    state_d = ArbIdle;
        endcase
    end

    always_comb begin
        rdy = '0;
        if (state_q == ArbXfer) rdy[sel_q] = out_rdy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q      <= '0;
            out_ctrl_q      <= '0;
            out_wr_q        <= 1'b0;
            grant_timeout_q <= 1'b0;
        end else begin
            out_wr_q        <= accept;
            grant_timeout_q <= timeout_hit;
            if (state_q == ArbXfer) begin
                out_data_q <= data[sel_q];
                out_ctrl_q <= ctrl[sel_q];
            end
        end
    end

    assign {in_ack3, in_ack2, in_ack1, in_ack0} = ack_q;
    assign {in_rdy3, in_rdy2, in_rdy1, in_rdy0} = rdy;
    assign out_data      = out_data_q;
    assign out_ctrl      = out_ctrl_q;
    assign out_wr        = out_wr_q;
    assign grant_timeout = grant_timeout_q;
endmodule

// File: tb/tb_core_output_arbiter.sv
// Directed bench for core_output_arbiter: single core, contention, backpressure, reset, isolation.
// The timeout scenario runs only when ARB_GRANT_TIMEOUT_EN is defined.
module tb_core_output_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] d [4];
    logic [7:0]  c [4];
    logic [3:0]  wr, req, ack, rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr, out_rdy, grant_timeout;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    core_output_arbiter #(.NUM_CORES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .in_data0(d[0]), .in_ctrl0(c[0]), .in_wr0(wr[0]), .in_req0(req[0]),
        .in_ack0(ack[0]), .in_rdy0(rdy[0]),
        .in_data1(d[1]), .in_ctrl1(c[1]), .in_wr1(wr[1]), .in_req1(req[1]),
        .in_ack1(ack[1]), .in_rdy1(rdy[1]),
        .in_data2(d[2]), .in_ctrl2(c[2]), .in_wr2(wr[2]), .in_req2(req[2]),
        .in_ack2(ack[2]), .in_rdy2(rdy[2]),
        .in_data3(d[3]), .in_ctrl3(c[3]), .in_wr3(wr[3]), .in_req3(req[3]),
        .in_ack3(ack[3]), .in_rdy3(rdy[3]),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .grant_timeout(grant_timeout)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the grant, send a 3-word packet, release, then re-request.
    task automatic serve(input int core, input int g);
        int t = 0;
        while (ack == 4'd0 && t < 8) begin
            cyc();
            t++;
        end
        chk("t2_grant", 64'(ack), 64'(4'b0001 << core));
        for (int k = 0; k < 3; k++) begin
            d[core]  = 64'(core * 256 + g * 16 + k);
            wr[core] = 1'b1;
            #1 chk("t2_rdy", 64'(rdy), 64'(4'b0001 << core));
            cyc();
            chk("t2_word", out_data, 64'(core * 256 + g * 16 + k));
        end
        wr[core]  = 1'b0;
        req[core] = 1'b0;
        cyc();
        chk("t2_release", {62'd0, ack[core], out_wr}, 64'd0);
        req[core] = 1'b1;
    endtask

    initial begin
        int w;
        reset   = 1'b1;
        req     = 4'd0;
        wr      = 4'd0;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = 64'd0;
            c[i] = 8'd0;
        end
        cyc();
        cyc();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_wr", 64'(out_wr), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_gto", 64'(grant_timeout), 64'd0);
        reset = 1'b0;

        // T1: single core 2, five words, one-cycle forwarding
        req[2] = 1'b1;
        cyc();
        chk("t1_ack", 64'(ack), 64'h4);
        chk("t1_rdy", 64'(rdy), 64'h4);
        for (int k = 1; k <= 5; k++) begin
            d[2]  = 64'h0A00_0000_0000_0000 | 64'(k);
            c[2]  = (k == 1) ? 8'hFF : 8'h00;
            wr[2] = 1'b1;
            cyc();
            chk("t1_wr", 64'(out_wr), 64'd1);
            chk("t1_data", out_data, 64'h0A00_0000_0000_0000 | 64'(k));
            chk("t1_ctrl", 64'(out_ctrl), (k == 1) ? 64'hFF : 64'h00);
        end
        wr[2] = 1'b0;
        cyc();
        chk("t1_idle_wr", 64'(out_wr), 64'd0);
        chk("t1_hold_ack", 64'(ack), 64'h4);
        req[2] = 1'b0;
        cyc();
        chk("t1_drop_ack", 64'(ack), 64'd0);
        cyc();

        // T2: all four request from reset; order 0,1,2,3,0,1
        reset = 1'b1;
        req   = 4'hF;
        cyc();
        reset = 1'b0;
        for (int g = 0; g < 6; g++) serve(g % 4, g);
        req = 4'd0;
        cyc();
        cyc();

        // T3: backpressure on core 1, out_rdy 1,0,0,1,1,1
        req[1] = 1'b1;
        cyc();
        chk("t3_ack", 64'(ack), 64'h2);
        w = 0;
        for (int i = 0; i < 6; i++) begin
            out_rdy = pat[i];
            d[1]    = 64'h1100 + 64'(w);
            wr[1]   = 1'b1;
            #1 chk("t3_rdy", 64'(rdy), {60'd0, 2'b00, pat[i], 1'b0});
            cyc();
            chk("t3_wr", 64'(out_wr), 64'(pat[i]));
            if (pat[i]) begin
                chk("t3_data", out_data, 64'h1100 + 64'(w));
                w++;
            end
        end
        chk("t3_count", 64'(w), 64'd4);
        wr[1]   = 1'b0;
        req[1]  = 1'b0;
        out_rdy = 1'b1;
        cyc();
        chk("t3_rel", 64'(ack), 64'd0);
        cyc();

        // T5: core 2 mid-packet reset; afterwards core 0 wins over 1 and 2
        req[2] = 1'b1;
        cyc();
        chk("t5_ack", 64'(ack), 64'h4);
        for (int k = 0; k < 2; k++) begin
            d[2]  = 64'h5500 + 64'(k);
            wr[2] = 1'b1;
            cyc();
            chk("t5_data", out_data, 64'h5500 + 64'(k));
        end
        d[2]  = 64'h5502;
        reset = 1'b1;
        cyc();
        chk("t5_ack_rst", 64'(ack), 64'd0);
        chk("t5_wr_rst", 64'(out_wr), 64'd0);
        chk("t5_data_rst", out_data, 64'd0);
        chk("t5_rdy_rst", 64'(rdy), 64'd0);
        reset = 1'b0;
        wr    = 4'd0;
        req   = 4'b0111;
        cyc();
        chk("t5_prio", 64'(ack), 64'h1);
        req = 4'd0;
        cyc();
        cyc();

        // T4: core 3 granted, core 0 writes junk without a grant
        req[3] = 1'b1;
        cyc();
        chk("t4_ack", 64'(ack), 64'h8);
        d[0]  = 64'hDEAD;
        wr[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d[3]  = 64'h3300 + 64'(k);
            wr[3] = 1'b1;
            #1 chk("t4_rdy", 64'(rdy), 64'h8);
            cyc();
            chk("t4_data", out_data, 64'h3300 + 64'(k));
        end
        d[3]  = 64'h33FF;
        wr[3] = 1'b0;
        cyc();
        chk("t4_nowr", 64'(out_wr), 64'd0);
        chk("t4_nodead", out_data, 64'h33FF);
        wr[0]  = 1'b0;
        req[3] = 1'b0;
        cyc();
        cyc();
        chk("t4_gto", 64'(grant_timeout), 64'd0);

`ifdef ARB_GRANT_TIMEOUT_EN
        // T6: core 1 silent for 16 cycles, forced off; core 2 next; core 1 held out
        req[1] = 1'b1;
        req[2] = 1'b1;
        cyc();
        chk("t6_ack", 64'(ack), 64'h2);
        for (int i = 1; i < 16; i++) begin
            cyc();
            chk("t6_hold", {59'd0, grant_timeout, ack}, 64'h2);
        end
        cyc();
        chk("t6_pulse", {59'd0, grant_timeout, ack}, 64'h10);
        cyc();
        chk("t6_pulse_end", 64'(grant_timeout), 64'd0);
        cyc();
        chk("t6_next", 64'(ack), 64'h4);
        req[2] = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("t6_heldout", 64'(ack), 64'd0);
        req[1] = 1'b0;
        cyc();
        req[1] = 1'b1;
        cyc();
        chk("t6_regrant", 64'(ack), 64'h2);
        req = 4'd0;
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
